// File: rtl/fft_sdf_ctrl.sv
// -----------------------------------------------------------------------------
// fft_sdf_ctrl
// Sequencing controller for a radix-2 single-path delay-feedback FFT pipeline
// of LOG2N cascaded butterfly/delay-line stages.
//
// It counts accepted samples, produces the common stage enable, the per-stage
// butterfly mode and twiddle ROM address, tracks pipeline fill, flags valid
// outputs with their index, and drains the last frame by feeding zeros.
//
// Optional build macro:
//   FFT_CTRL_BITREV_EN  defined   : o_out_idx is the natural frequency bin
//                                   (bit-reversed output stream position)
//                       undefined : o_out_idx is the stream position itself
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   i_in_valid   in   upstream sample present
//   o_in_ready   out  sample accepted when i_in_valid & o_in_ready
//   i_flush      in   request to drain the pipeline at a frame boundary
//   o_feed_zero  out  datapath input mux selects zero while draining
//   o_stage_en   out  enable for all stage registers / delay lines
//   o_bf_sel     out  [LOG2N] bit s: stage s butterfly mode (1 = compute)
//   o_tw_addr    out  [LOG2N*(LOG2N-1)] stage s twiddle index at
//                     [s*(LOG2N-1) +: LOG2N-1]
//   o_out_valid  out  pipeline output sample valid this cycle
//   o_out_idx    out  [LOG2N] index of the current output sample
//   o_busy       out  controller not idle
//
// State table:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | no frame in progress, waiting for the first sample
//   S_FILL  | pipeline filling, no valid outputs yet
//   S_RUN   | pipeline full, one output per accepted input
//   S_FLUSH | draining the last frame, zeros injected every cycle
// -----------------------------------------------------------------------------
module fft_sdf_ctrl #(
    parameter int N     = 32,
    parameter int LOG2N = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic                         i_flush,
    output logic                         o_feed_zero,
    output logic                         o_stage_en,
    output logic [LOG2N-1:0]             o_bf_sel,
    output logic [LOG2N*(LOG2N-1)-1:0]   o_tw_addr,
    output logic                         o_out_valid,
    output logic [LOG2N-1:0]             o_out_idx,
    output logic                         o_busy
);

    localparam int              W          = LOG2N - 1;
    localparam logic [LOG2N-1:0] C_LAST    = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] C_PRELAST = LOG2N'(N - 2);
    localparam logic [LOG2N-1:0] C_ONE     = LOG2N'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LOG2N-1:0] r_cnt;
    logic [LOG2N-1:0] w_cnt_nxt;
    logic [LOG2N-1:0] r_fill_cnt;
    logic [LOG2N-1:0] w_fill_cnt_nxt;
    logic [LOG2N-1:0] r_flush_cnt;
    logic [LOG2N-1:0] w_flush_cnt_nxt;

    logic             w_flush_take;
    logic             w_in_ready;
    logic             w_advance;
    logic             w_full;
    logic [LOG2N-1:0] w_bf_sel;
    logic [LOG2N-1:0] w_out_pos;
    logic [LOG2N-1:0] w_idx;

    // Offset of stage s in the frame: each earlier stage j delays by N>>(j+1).
    function automatic int stage_ofs(input int s);
        int p;
        p = 0;
        for (int j = 0; j < s; j++) begin
            p = p + (N >> (j + 1));
        end
        return p;
    endfunction

    // A flush only takes effect on a frame boundary; the sample offered in
    // that cycle is refused so the new frame does not start.
    assign w_flush_take = (r_state == S_RUN) && i_flush && (r_cnt == '0);
    assign w_in_ready   = (r_state != S_FLUSH) && !w_flush_take;
    assign w_advance    = (i_in_valid && w_in_ready) || (r_state == S_FLUSH);
    assign w_full       = (r_fill_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_fill_cnt  <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fill_cnt  <= w_fill_cnt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_fill_cnt_nxt  = r_fill_cnt;
        w_flush_cnt_nxt = r_flush_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_advance) begin
                    w_state_nxt    = S_FILL;
                    w_cnt_nxt      = C_ONE;
                    w_fill_cnt_nxt = C_ONE;
                end
            end
            S_FILL: begin
                if (w_advance) begin
                    w_cnt_nxt      = r_cnt + C_ONE;
                    w_fill_cnt_nxt = r_fill_cnt + C_ONE;
                    if (r_fill_cnt == C_PRELAST) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_flush_take) begin
                    w_state_nxt     = S_FLUSH;
                    w_flush_cnt_nxt = '0;
                end else if (w_advance) begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            S_FLUSH: begin
                // N-1 zero advances push the last frame's outputs out.
                if (r_flush_cnt == C_PRELAST) begin
                    w_state_nxt     = S_IDLE;
                    w_cnt_nxt       = '0;
                    w_fill_cnt_nxt  = '0;
                    w_flush_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt       = r_cnt + C_ONE;
                    w_flush_cnt_nxt = r_flush_cnt + C_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Per-stage local count ls = (cnt - P_s) mod N. Only the bits at and
    // below the butterfly-select bit matter, so ls is kept that narrow.
    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        localparam logic [LOG2N-1:0] P_S = LOG2N'(stage_ofs(s));
        logic [LOG2N-1-s:0] w_ls;

        assign w_ls        = r_cnt[LOG2N-1-s:0] - P_S[LOG2N-1-s:0];
        assign w_bf_sel[s] = w_ls[LOG2N-1-s];

        if (s < LOG2N - 1) begin : g_tw
            assign o_tw_addr[s*W +: W] = w_bf_sel[s] ? '0
                                       : (W'(w_ls[LOG2N-2-s:0]) << s);
        end else begin : g_tw_last
            // The final stage only uses the trivial twiddle.
            assign o_tw_addr[s*W +: W] = '0;
        end
    end

    assign w_out_pos = r_cnt + C_ONE;

`ifdef FFT_CTRL_BITREV_EN
    for (genvar i = 0; i < LOG2N; i++) begin : g_rev
        assign w_idx[i] = w_out_pos[LOG2N-1-i];
    end
`else
    assign w_idx = w_out_pos;
`endif

    assign o_in_ready  = w_in_ready;
    assign o_stage_en  = w_advance;
    assign o_feed_zero = (r_state == S_FLUSH);
    assign o_bf_sel    = w_bf_sel;
    assign o_out_valid = w_advance && w_full;
    // Index is parked at 0 until the pipeline is full so idle/reset show 0;
    // once full it follows cnt and therefore holds through stalls.
    assign o_out_idx   = w_full ? w_idx : '0;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
module tb_fft_sdf_ctrl;

    localparam int N  = 32;
    localparam int L  = 5;
    localparam int TW = L * (L - 1);

`ifdef FFT_CTRL_BITREV_EN
    localparam int EXP_P1 = 16;
    localparam int EXP_P3 = 24;
`else
    localparam int EXP_P1 = 1;
    localparam int EXP_P3 = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_in_valid = 1'b0;
    logic          i_flush = 1'b0;
    logic          o_in_ready;
    logic          o_feed_zero;
    logic          o_stage_en;
    logic [L-1:0]  o_bf_sel;
    logic [TW-1:0] o_tw_addr;
    logic          o_out_valid;
    logic [L-1:0]  o_out_idx;
    logic          o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    fft_sdf_ctrl #(.N(N), .LOG2N(L)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_flush     (i_flush),
        .o_feed_zero (o_feed_zero),
        .o_stage_en  (o_stage_en),
        .o_bf_sel    (o_bf_sel),
        .o_tw_addr   (o_tw_addr),
        .o_out_valid (o_out_valid),
        .o_out_idx   (o_out_idx),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Stage offsets for N=32, written out by hand.
    function automatic int m_ofs(input int s);
        int t[5];
        t = '{0, 16, 24, 28, 30};
        return t[s];
    endfunction

    function automatic logic [L-1:0] m_bf(input int c);
        logic [L-1:0] r;
        int ls;
        r = '0;
        for (int s = 0; s < L; s++) begin
            ls = (c - m_ofs(s) + N) % N;
            r[s] = ((ls >> (L - 1 - s)) & 1) != 0;
        end
        return r;
    endfunction

    function automatic logic [TW-1:0] m_tw(input int c);
        logic [TW-1:0] r;
        int ls;
        r = '0;
        for (int s = 0; s < L - 1; s++) begin
            ls = (c - m_ofs(s) + N) % N;
            if (((ls >> (L - 1 - s)) & 1) == 0)
                r[s*(L-1) +: (L-1)] = (L-1)'((ls % (1 << (L - 1 - s))) * (1 << s));
        end
        return r;
    endfunction

    function automatic int m_idx(input int c);
        int p;
        int r;
        p = (c + 1) % N;
`ifdef FFT_CTRL_BITREV_EN
        r = 0;
        for (int i = 0; i < L; i++) r = r | (((p >> i) & 1) << (L - 1 - i));
`else
        r = p;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic e_rdy, input logic e_en,
                            input logic e_fz, input logic e_ov, input logic e_busy,
                            input int c, input logic full);
        chk({tag, ".in_ready"},  32'(o_in_ready),  32'(e_rdy));
        chk({tag, ".stage_en"},  32'(o_stage_en),  32'(e_en));
        chk({tag, ".feed_zero"}, 32'(o_feed_zero), 32'(e_fz));
        chk({tag, ".out_valid"}, 32'(o_out_valid), 32'(e_ov));
        chk({tag, ".busy"},      32'(o_busy),      32'(e_busy));
        chk({tag, ".bf_sel"},    32'(o_bf_sel),    32'(m_bf(c)));
        chk({tag, ".tw_addr"},   32'(o_tw_addr),   32'(m_tw(c)));
        chk({tag, ".out_idx"},   32'(o_out_idx),   full ? 32'(m_idx(c)) : 32'd0);
    endtask

    task automatic drive(input logic v, input logic f);
        i_in_valid = v;
        i_flush    = f;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 32 samples from IDLE; flush offered during FILL must be ignored.
    task automatic fill_frame(input string tag);
        for (int k = 0; k < N; k++) begin
            drive(1'b1, k == 5);
            chk_ctrl(tag, 1'b1, 1'b1, 1'b0, k == N - 1, k != 0, k, k == N - 1);
            chk({tag, ".bf0"}, 32'(o_bf_sel[0]), 32'(k >= 16));
            if (k == N - 1) chk({tag, ".first_idx"}, 32'(o_out_idx), 32'd0);
            step();
        end
    endtask

    initial begin
        // Reset state
        i_in_valid = 1'b0;
        i_flush    = 1'b0;
        #3;
        chk_ctrl("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        #4;
        rst_n = 1'b1;

        // First frame fills the pipeline
        fill_frame("fill1");

        // RUN, first lap up to cnt 6, with out_idx spot values at pos 1 and 3
        for (int c = 0; c < 7; c++) begin
            drive(1'b1, 1'b0);
            chk_ctrl("run", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, c, 1'b1);
            if (c == 0) chk("idx.pos1", 32'(o_out_idx), 32'(EXP_P1));
            if (c == 2) chk("idx.pos3", 32'(o_out_idx), 32'(EXP_P3));
            step();
        end

        // Stall at cnt 7 for 5 cycles
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0);
            chk_ctrl("stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7, 1'b1);
            step();
        end

        // Resume at cnt 7; flush at cnt 9 is ignored; hand values at cnt 20
        for (int c = 7; c < N; c++) begin
            drive(1'b1, c == 9);
            chk_ctrl((c == 9) ? "flush_ignored" : "run2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, c, 1'b1);
            if (c == 20) begin
                chk("cnt20.bf_sel", 32'(o_bf_sel), 32'h05);
                chk("cnt20.tw_addr", 32'(o_tw_addr), 32'h00080);
            end
            step();
        end

        // Flush honoured at cnt 0: sample refused
        drive(1'b1, 1'b1);
        chk_ctrl("flush_req", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        step();

        // 31 zero-fed advances, in_valid toggling is irrelevant
        for (int f = 0; f < N - 1; f++) begin
            drive(logic'(f % 2), 1'b0);
            chk_ctrl("flush", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, f, 1'b1);
            step();
        end

        drive(1'b0, 1'b0);
        chk_ctrl("idle_after_flush", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Second frame, flush, then reset partway through the flush
        fill_frame("fill2");
        drive(1'b1, 1'b1);
        chk_ctrl("flush_req2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        step();
        for (int f = 0; f < 10; f++) begin
            drive(1'b0, 1'b0);
            chk_ctrl("flush2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, f, 1'b1);
            step();
        end
        drive(1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_ctrl("reset_mid_flush", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        #1;
        rst_n = 1'b1;

        // Fresh frame after reset: first out_valid on the 32nd sample
        fill_frame("fill3");
        drive(1'b1, 1'b0);
        chk_ctrl("run3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1);
        step();
        drive(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
